// File: rtl/ho_decision_ctrl.sv
// Handover decision controller: picks the serving base station from per-cycle
// RSSI samples with hysteresis, time-to-trigger and a post-handover guard.
module ho_decision_ctrl #(
  parameter int RSSI_W = 8,
  parameter int HYST   = 4,
  parameter int TTT    = 3,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              meas_valid,
  input  logic [RSSI_W-1:0] rssi_bs1,
  input  logic [RSSI_W-1:0] rssi_bs2,
  input  logic [RSSI_W-1:0] rssi_bs3,
  output logic [1:0]        serving_target,
  output logic              attached,
  output logic              ho_pulse,
  output logic              ho_busy,
  output logic [7:0]        ho_count
);

  localparam int CW = (TTT   < 2) ? 1 : $clog2(TTT);
  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD);
  localparam logic [CW-1:0]     TTT_M1   = CW'(TTT - 1);
  localparam logic [GW-1:0]     GUARD_M1 = GW'(GUARD - 1);
  localparam logic [RSSI_W:0]   HYST_X   = (RSSI_W+1)'(HYST);

  typedef enum logic [1:0] {DETACHED, SERVING, CAND, GUARD_ST} state_t;

  state_t          state_q;
  logic [1:0]      srv_q, cand_q;
  logic            att_q, pulse_q, busy_q;
  logic [7:0]      ho_cnt_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gcnt_q;

  logic [1:0]        best_all, best_nb;
  logic [RSSI_W-1:0] r_srv, r_nb, r_ba;
  logic              qualify;

  function automatic logic [RSSI_W-1:0] pick(input logic [1:0] idx,
      input logic [RSSI_W-1:0] a, input logic [RSSI_W-1:0] b,
      input logic [RSSI_W-1:0] c);
    case (idx)
      2'd0:    pick = a;
      2'd1:    pick = b;
      default: pick = c;
    endcase
  endfunction

  // Strongest overall / strongest neighbour (ties to lowest index) and the hysteresis test
  always_comb begin
    best_all = 2'd0;
    if (rssi_bs2 > rssi_bs1) best_all = 2'd1;
    r_ba = pick(best_all, rssi_bs1, rssi_bs2, rssi_bs3);
    if (rssi_bs3 > r_ba) best_all = 2'd2;
    case (srv_q)
      2'd0:    best_nb = (rssi_bs3 > rssi_bs2) ? 2'd2 : 2'd1;
      2'd1:    best_nb = (rssi_bs3 > rssi_bs1) ? 2'd2 : 2'd0;
      default: best_nb = (rssi_bs2 > rssi_bs1) ? 2'd1 : 2'd0;
    endcase
    r_srv   = pick(srv_q,   rssi_bs1, rssi_bs2, rssi_bs3);
    r_nb    = pick(best_nb, rssi_bs1, rssi_bs2, rssi_bs3);
    qualify = {1'b0, r_nb} > ({1'b0, r_srv} + HYST_X);
  end

  // Decision FSM; all outputs registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DETACHED;
      srv_q    <= 2'd3;
      cand_q   <= 2'd3;
      att_q    <= 1'b0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      ho_cnt_q <= 8'd0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        DETACHED: if (meas_valid) begin
          srv_q   <= best_all;
          att_q   <= 1'b1;
          pulse_q <= 1'b1;
          gcnt_q  <= GUARD_M1;
          busy_q  <= 1'b1;
          state_q <= GUARD_ST;
        end
        SERVING: if (meas_valid && qualify) begin
          cand_q <= best_nb;
          busy_q <= 1'b1;
          if (TTT == 1) begin
            srv_q    <= best_nb;
            pulse_q  <= 1'b1;
            ho_cnt_q <= ho_cnt_q + 8'd1;
            cnt_q    <= '0;
            gcnt_q   <= GUARD_M1;
            state_q  <= GUARD_ST;
          end else begin
            cnt_q   <= CW'(1);
            state_q <= CAND;
          end
        end
        CAND: if (meas_valid) begin
          if (!qualify) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= SERVING;
          end else if (best_nb != cand_q) begin
            cand_q <= best_nb;
            cnt_q  <= CW'(1);
          end else if (cnt_q == TTT_M1) begin
            srv_q    <= cand_q;
            pulse_q  <= 1'b1;
            ho_cnt_q <= ho_cnt_q + 8'd1;
            cnt_q    <= '0;
            gcnt_q   <= GUARD_M1;
            state_q  <= GUARD_ST;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (gcnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= SERVING;
          end else begin
            gcnt_q <= gcnt_q - GW'(1);
          end
        end
      endcase
    end
  end

  assign serving_target = srv_q;
  assign attached       = att_q;
  assign ho_pulse       = pulse_q;
  assign ho_busy        = busy_q;
  assign ho_count       = ho_cnt_q;

endmodule

// File: tb/tb_ho_decision_ctrl.sv
// Directed bench for ho_decision_ctrl (RSSI_W=8, HYST=4, TTT=3, GUARD=4).
module tb_ho_decision_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       meas_valid = 1'b0;
  logic [7:0] rssi_bs1 = '0, rssi_bs2 = '0, rssi_bs3 = '0;
  logic [1:0] serving_target;
  logic       attached, ho_pulse, ho_busy;
  logic [7:0] ho_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_srv;
  logic [7:0] exp_cnt;

  ho_decision_ctrl #(.RSSI_W(8), .HYST(4), .TTT(3), .GUARD(4)) dut (
    .clk(clk), .reset(reset), .meas_valid(meas_valid),
    .rssi_bs1(rssi_bs1), .rssi_bs2(rssi_bs2), .rssi_bs3(rssi_bs3),
    .serving_target(serving_target), .attached(attached),
    .ho_pulse(ho_pulse), .ho_busy(ho_busy), .ho_count(ho_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] srv, input logic att,
                         input logic pls, input logic busy, input logic [7:0] cnt);
    chk({tag, ".srv"},   32'(serving_target), 32'(srv));
    chk({tag, ".att"},   32'(attached),       32'(att));
    chk({tag, ".pulse"}, 32'(ho_pulse),       32'(pls));
    chk({tag, ".busy"},  32'(ho_busy),        32'(busy));
    chk({tag, ".cnt"},   32'(ho_count),       32'(cnt));
  endtask

  // one valid sample, outputs settled 1 time unit after the sampling edge
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    meas_valid = 1'b1; rssi_bs1 = a; rssi_bs2 = b; rssi_bs3 = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); meas_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; meas_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk_all("reset", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); reset = 1'b1;

    // attach to strongest (BS2)
    step(10, 50, 20);
    chk_all("attach", 2'd1, 1'b1, 1'b1, 1'b1, 8'd0);
    idle(1);
    chk("attach.pulse_drop", 32'(ho_pulse), 32'd0);
    idle(6);
    chk("attach.guard_done", 32'(ho_busy), 32'd0);

    // tie attaches to lowest index
    do_reset();
    step(40, 40, 10);
    chk_all("tie", 2'd0, 1'b1, 1'b1, 1'b1, 8'd0);
    idle(7);

    // hysteresis: 54 is not > 50+4
    for (int i = 0; i < 10; i++) begin
      step(50, 0, 54);
      chk("hyst.nopulse", 32'(ho_pulse), 32'd0);
      chk("hyst.srv", 32'(serving_target), 32'd0);
      chk("hyst.busy", 32'(ho_busy), 32'd0);
    end
    step(50, 0, 55);
    chk("hyst.cand1", 32'(ho_busy), 32'd1);
    step(50, 0, 55);
    chk("hyst.cand2", 32'(ho_pulse), 32'd0);
    step(50, 0, 55);
    chk_all("hyst.ho", 2'd2, 1'b1, 1'b1, 1'b1, 8'd1);
    idle(1);
    chk("hyst.pulse_drop", 32'(ho_pulse), 32'd0);
    idle(6);

    // TTT interruption, serving BS3; BS2 qualifies at 60 > 54
    step(0, 60, 50);
    step(0, 60, 50);
    chk("ttt.cand", 32'(ho_busy), 32'd1);
    step(0, 50, 50);
    chk("ttt.abort", 32'(ho_busy), 32'd0);
    step(0, 60, 50);
    idle(3);
    chk("ttt.gap_hold", 32'(ho_busy), 32'd1);
    step(0, 60, 50);
    chk("ttt.no_ho", 32'(ho_pulse), 32'd0);
    chk("ttt.srv_hold", 32'(serving_target), 32'd2);
    step(0, 60, 50);
    chk_all("ttt.ho", 2'd1, 1'b1, 1'b1, 1'b1, 8'd2);
    idle(7);

    // candidate switch, serving BS2: BS1 twice, then BS3 becomes stronger
    step(60, 50, 0);
    step(60, 50, 0);
    step(60, 50, 70);
    step(60, 50, 70);
    chk("sw.no_ho", 32'(ho_pulse), 32'd0);
    chk("sw.srv_hold", 32'(serving_target), 32'd1);
    step(60, 50, 70);
    chk_all("sw.ho", 2'd2, 1'b1, 1'b1, 1'b1, 8'd3);

    // guard: strong BS1 every cycle right after the handover
    for (int i = 1; i <= 6; i++) begin
      step(90, 0, 10);
      chk("guard.nopulse", 32'(ho_pulse), 32'd0);
      chk("guard.srv", 32'(serving_target), 32'd2);
      if (i == 3) chk("guard.busy3", 32'(ho_busy), 32'd1);
      if (i == 4) chk("guard.exit", 32'(ho_busy), 32'd0);
    end
    step(90, 0, 10);
    chk_all("guard.ho", 2'd0, 1'b1, 1'b1, 1'b1, 8'd4);

    // back-to-back handovers every GUARD+TTT cycles up to wrap
    exp_srv = 2'd0;
    exp_cnt = 8'd4;
    for (int k = 0; k < 252; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (exp_srv == 2'd0) step(10, 0, 90);
        else                 step(90, 0, 10);
      end
      exp_srv = (exp_srv == 2'd0) ? 2'd2 : 2'd0;
      exp_cnt = exp_cnt + 8'd1;
      chk("wrap.pulse", 32'(ho_pulse), 32'd1);
      chk("wrap.srv", 32'(serving_target), 32'(exp_srv));
      chk("wrap.cnt", 32'(ho_count), 32'(exp_cnt));
      if (k == 250) chk("wrap.at255", 32'(ho_count), 32'd255);
    end
    chk("wrap.zero", 32'(ho_count), 32'd0);
    idle(7);

    // async reset mid-CAND, serving BS1 (exp_srv == 0)
    step(10, 0, 90);
    chk("ar.cand", 32'(ho_busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk_all("ar.async", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); reset = 1'b1; meas_valid = 1'b0;
    idle(2);
    chk_all("ar.idle", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(10, 50, 20);
    chk_all("ar.reattach", 2'd1, 1'b1, 1'b1, 1'b1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
